// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix result readout path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mm_pkg;

  // Width of one matrix result word.
  localparam int WORD_W = 32;

  // Readout FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/mm_index_counter.sv
// Row/column walker over an n x n result matrix in row-major order.
// Latency: row/column update on the edge where inc or clr is high; last is combinational.
// Backpressure: none of its own; it only advances when inc is asserted by the owner.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - return to (0,0) on the next edge (wins over inc)
//   inc        - advance one position, wrapping column into the next row
//   row/column - current index
//   last       - current index is (n-1, n-1)
module mm_index_counter #(
  parameter int LOG_SIZE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [LOG_SIZE-1:0] row,
  output logic [LOG_SIZE-1:0] column,
  output logic                last
);

  localparam logic [LOG_SIZE-1:0] IDX_MAX = '1;

  logic [LOG_SIZE-1:0] row_q, row_d;
  logic [LOG_SIZE-1:0] column_q, column_d;

  always_comb begin
    row_d    = row_q;
    column_d = column_q;
    if (clr) begin
      row_d    = '0;
      column_d = '0;
    end else if (inc) begin
      if (column_q == IDX_MAX) begin
        column_d = '0;
        row_d    = row_q + 1'b1;
      end else begin
        column_d = column_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      column_q <= '0;
    end else begin
      row_q    <= row_d;
      column_q <= column_d;
    end
  end

  assign row    = row_q;
  assign column = column_q;
  assign last   = (row_q == IDX_MAX) && (column_q == IDX_MAX);

endmodule

// File: rtl/matrix_result_reader.sv
// Streams an n x n multiplier result matrix row-major onto a valid/ack word port.
// Latency: out_stb rises on the second edge after mm_out_stb is raised; 2-cycle minimum word period.
// Backpressure: a word is held stable while out_ack is low; the multiplier is released only after the last word.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   mm_out_stb/ack    - four-phase frame handshake with the multiplier
//   mm_row/column     - index presented to the multiplier result memory
//   mm_output_select  - selects the multiplier result memory for readout
//   mm_out_number     - result word at (mm_row, mm_column)
//   out_number/stb    - downstream word and its valid
//   out_ack           - downstream accept
//   out_last          - marks the final word of the frame
//   busy              - any state other than IDLE
module matrix_result_reader
  import mm_pkg::*;
#(
  parameter int log_size = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mm_out_stb,
  output logic                mm_out_ack,
  output logic [log_size-1:0] mm_row,
  output logic [log_size-1:0] mm_column,
  output logic                mm_output_select,
  input  logic [WORD_W-1:0]   mm_out_number,
  output logic [WORD_W-1:0]   out_number,
  output logic                out_stb,
  input  logic                out_ack,
  output logic                out_last,
  output logic                busy
);

  rd_state_e           state_q, state_d;
  logic [WORD_W-1:0]   out_number_q, out_number_d;
  logic                out_stb_q, out_stb_d;
  logic                out_last_q, out_last_d;

  logic                cnt_inc;
  logic                cnt_clr;
  logic                cnt_last;

  // Index walker; it only moves on a downstream handshake, so row/column
  // stay put for the whole SETTLE/SEND span of a word.
  mm_index_counter #(
    .LOG_SIZE (log_size)
  ) u_index (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .row    (mm_row),
    .column (mm_column),
    .last   (cnt_last)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_number_q <= '0;
      out_stb_q    <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_number_q <= out_number_d;
      out_stb_q    <= out_stb_d;
      out_last_q   <= out_last_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    out_number_d = out_number_q;
    out_stb_d    = out_stb_q;
    out_last_d   = out_last_q;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mm_out_stb) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // One cycle for the result memory read at the new index to settle;
        // the word is captured here so out_number never sees mm_out_number
        // combinationally.
        out_number_d = mm_out_number;
        out_stb_d    = 1'b1;
        out_last_d   = cnt_last;
        state_d      = SEND;
      end
      SEND: begin
        if (out_stb_q && out_ack) begin
          out_stb_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            cnt_clr    = 1'b1;
            state_d    = RELEASE;
          end else begin
            cnt_inc = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      RELEASE: begin
        // Hold the acknowledge until the multiplier withdraws its strobe.
        if (!mm_out_stb) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    mm_output_select = (state_q == SETTLE) || (state_q == SEND);
    mm_out_ack       = (state_q == RELEASE);
    busy             = (state_q != IDLE);
  end

  assign out_number = out_number_q;
  assign out_stb    = out_stb_q;
  assign out_last   = out_last_q;

endmodule
